// File: rtl/mult_div_unit_pkg.sv
// Shared constants, opcode/state enums and opcode decode helpers for the multiply/divide unit.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package mult_div_unit_pkg;

  localparam int WORD_LEN  = 32;
  localparam int MD_OP_LEN = 2;
  // One iteration per operand bit; not independently tunable.
  localparam int ITER      = WORD_LEN;
  localparam int CNT_W     = $clog2(ITER);

  typedef enum logic [MD_OP_LEN-1:0] {
    MD_MULT  = 2'd0,
    MD_MULTU = 2'd1,
    MD_DIV   = 2'd2,
    MD_DIVU  = 2'd3
  } md_op_e;

  typedef enum logic [1:0] {
    MD_IDLE = 2'd0,
    MD_RUN  = 2'd1,
    MD_FIX  = 2'd2
  } md_state_e;

  function automatic logic op_is_div(input md_op_e op);
    return (op == MD_DIV) || (op == MD_DIVU);
  endfunction

  function automatic logic op_is_signed(input md_op_e op);
    return (op == MD_MULT) || (op == MD_DIV);
  endfunction

endpackage

// File: rtl/mult_div_unit_if.sv
// Request/result bundle between the EX stage and the multiply/divide unit.
// Latency: n/a (wires only).
// Backpressure: none here; the unit's busy output stalls the pipeline.
// master: start/op/val1/val2/wr_hi/wr_lo/wr_data out, busy/done/div_zero/hi/lo in.
// slave : the mirror image, used by mult_div_unit.
interface mult_div_unit_if;
  import mult_div_unit_pkg::*;

  logic                start;
  md_op_e              op;
  logic [WORD_LEN-1:0] val1;
  logic [WORD_LEN-1:0] val2;
  logic                wr_hi;
  logic                wr_lo;
  logic [WORD_LEN-1:0] wr_data;
  logic                busy;
  logic                done;
  logic                div_zero;
  logic [WORD_LEN-1:0] hi;
  logic [WORD_LEN-1:0] lo;

  modport master (
    output start, op, val1, val2, wr_hi, wr_lo, wr_data,
    input  busy, done, div_zero, hi, lo
  );

  modport slave (
    input  start, op, val1, val2, wr_hi, wr_lo, wr_data,
    output busy, done, div_zero, hi, lo
  );

endinterface

// File: rtl/md_sign_fix.sv
// Conditional two's-complement negation of a {hi,lo} word pair, either as one 64-bit value or per half.
// Latency: combinational.
// Backpressure: none.
// Ports: in_val {hi,lo}; neg_wide negates all 64 bits (takes priority); neg_hi/neg_lo negate one half; out_val result.
module md_sign_fix
  import mult_div_unit_pkg::*;
(
  input  logic [2*WORD_LEN-1:0] in_val,
  input  logic                  neg_wide,
  input  logic                  neg_hi,
  input  logic                  neg_lo,
  output logic [2*WORD_LEN-1:0] out_val
);

  logic [WORD_LEN-1:0] in_hi;
  logic [WORD_LEN-1:0] in_lo;

  always_comb begin
    in_hi = in_val[2*WORD_LEN-1:WORD_LEN];
    in_lo = in_val[WORD_LEN-1:0];
    if (neg_wide) begin
      out_val = -in_val;
    end else begin
      out_val = {(neg_hi ? -in_hi : in_hi), (neg_lo ? -in_lo : in_lo)};
    end
  end

endmodule

// File: rtl/mult_div_unit.sv
// Iterative MIPS mult/multu/div/divu unit holding the HI/LO registers; also takes mthi/mtlo writes.
// Latency: start at edge E0, one iteration per edge E1..E32, result + done pulse at E33.
// Backpressure: busy (combinational) is high E0..E33; start is ignored while busy.
// Ports: clk, rst (sync, active high); md (slave modport): start/op/val1/val2, wr_hi/wr_lo/wr_data,
//        busy, done, div_zero, hi, lo.
module mult_div_unit
  import mult_div_unit_pkg::*;
(
  input  logic            clk,
  input  logic            rst,
  mult_div_unit_if.slave  md
);

  md_state_e             state_q, state_d;
  logic [CNT_W-1:0]      counter_q, counter_d;
  logic [2*WORD_LEN-1:0] acc_q, acc_d;       // mult: {partial, multiplier}; div: {remainder, quotient}
  logic [WORD_LEN-1:0]   opb_q, opb_d;       // multiplicand or divisor magnitude
  md_op_e                op_q, op_d;
  logic                  sign1_q, sign1_d;
  logic                  sign2_q, sign2_d;
  logic [WORD_LEN-1:0]   hi_q, hi_d;
  logic [WORD_LEN-1:0]   lo_q, lo_d;
  logic                  done_q, done_d;
  logic                  div_zero_q, div_zero_d;

  logic [2*WORD_LEN-1:0] prep_mag;
  logic [2*WORD_LEN-1:0] fix_val;
  logic                  prep_signed;
  logic                  fix_signed;
  logic                  fix_div;
  logic                  sign_diff;
  logic [WORD_LEN:0]     mul_sum;
  logic [WORD_LEN:0]     div_rem_sh;
  logic [WORD_LEN-1:0]   div_diff;
  logic                  div_ge;

  assign prep_signed = op_is_signed(md.op);
  assign fix_signed  = op_is_signed(op_q);
  assign fix_div     = op_is_div(op_q);
  assign sign_diff   = sign1_q ^ sign2_q;

  // Operand magnitudes; 0x80000000 maps to itself and is then treated as unsigned.
  md_sign_fix u_prep (
    .in_val   ({md.val1, md.val2}),
    .neg_wide (1'b0),
    .neg_hi   (prep_signed & md.val1[WORD_LEN-1]),
    .neg_lo   (prep_signed & md.val2[WORD_LEN-1]),
    .out_val  (prep_mag)
  );

  // Result sign correction: whole product for mult, quotient/remainder separately for div
  // (remainder follows the dividend, giving truncating division).
  md_sign_fix u_fix (
    .in_val   (acc_q),
    .neg_wide (fix_signed & ~fix_div & sign_diff),
    .neg_hi   (fix_signed &  fix_div & sign1_q),
    .neg_lo   (fix_signed &  fix_div & sign_diff),
    .out_val  (fix_val)
  );

  always_comb begin
    // Shift-add step: add the multiplicand if the current multiplier bit is set, then shift right.
    mul_sum    = {1'b0, acc_q[2*WORD_LEN-1:WORD_LEN]} + (acc_q[0] ? {1'b0, opb_q} : {(WORD_LEN+1){1'b0}});
    // Restoring step: shift the next dividend bit into the remainder and try the subtraction.
    // A set top bit means the shifted remainder already exceeds any 32-bit divisor.
    div_rem_sh = acc_q[2*WORD_LEN-1:WORD_LEN-1];
    div_ge     = div_rem_sh[WORD_LEN] | (div_rem_sh[WORD_LEN-1:0] >= opb_q);
    div_diff   = div_rem_sh[WORD_LEN-1:0] - opb_q;
  end

  always_comb begin
    state_d    = state_q;
    counter_d  = counter_q;
    acc_d      = acc_q;
    opb_d      = opb_q;
    op_d       = op_q;
    sign1_d    = sign1_q;
    sign2_d    = sign2_q;
    hi_d       = hi_q;
    lo_d       = lo_q;
    done_d     = 1'b0;
    div_zero_d = 1'b0;

    case (state_q)
      MD_IDLE: begin
        if (md.start) begin
          state_d   = MD_RUN;
          counter_d = '0;
          op_d      = md.op;
          sign1_d   = md.val1[WORD_LEN-1];
          sign2_d   = md.val2[WORD_LEN-1];
          if (op_is_div(md.op)) begin
            acc_d = {{WORD_LEN{1'b0}}, prep_mag[2*WORD_LEN-1:WORD_LEN]};
            opb_d = prep_mag[WORD_LEN-1:0];
          end else begin
            acc_d = {{WORD_LEN{1'b0}}, prep_mag[WORD_LEN-1:0]};
            opb_d = prep_mag[2*WORD_LEN-1:WORD_LEN];
          end
        end else begin
          if (md.wr_hi) hi_d = md.wr_data;
          if (md.wr_lo) lo_d = md.wr_data;
        end
      end

      MD_RUN: begin
        if (fix_div) begin
          acc_d = {(div_ge ? div_diff : div_rem_sh[WORD_LEN-1:0]), acc_q[WORD_LEN-2:0], div_ge};
        end else begin
          acc_d = {mul_sum, acc_q[WORD_LEN-1:1]};
        end
        counter_d = counter_q + 1'b1;
        if (counter_q == CNT_W'(ITER-1)) state_d = MD_FIX;
      end

      MD_FIX: begin
        state_d = MD_IDLE;
        done_d  = 1'b1;
        hi_d    = fix_val[2*WORD_LEN-1:WORD_LEN];
        lo_d    = fix_val[WORD_LEN-1:0];
        // With a zero divisor the remainder path already reproduces the dividend;
        // only the quotient needs forcing to all ones.
        if (fix_div && (opb_q == '0)) begin
          lo_d       = '1;
          div_zero_d = 1'b1;
        end
      end

      default: state_d = MD_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= MD_IDLE;
      counter_q  <= '0;
      acc_q      <= '0;
      opb_q      <= '0;
      op_q       <= MD_MULT;
      sign1_q    <= 1'b0;
      sign2_q    <= 1'b0;
      hi_q       <= '0;
      lo_q       <= '0;
      done_q     <= 1'b0;
      div_zero_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      counter_q  <= counter_d;
      acc_q      <= acc_d;
      opb_q      <= opb_d;
      op_q       <= op_d;
      sign1_q    <= sign1_d;
      sign2_q    <= sign2_d;
      hi_q       <= hi_d;
      lo_q       <= lo_d;
      done_q     <= done_d;
      div_zero_q <= div_zero_d;
    end
  end

  assign md.busy     = (state_q != MD_IDLE);
  assign md.done     = done_q;
  assign md.div_zero = div_zero_q;
  assign md.hi       = hi_q;
  assign md.lo       = lo_q;

endmodule
